// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared definitions for the reset sequencer.
//   - state_t : sequencer FSM state encoding
//                 ST_ASSERT=2'd0, ST_STRETCH=2'd1, ST_RELEASE=2'd2, ST_RUN=2'd3
//   - max_int : elaboration-time helper used to size the shared counter
//
//   Build option: RST_SEQ_LOCK_LOSS_EN is left undefined by default, so lock
//   loss while in RUN is ignored unless the build defines it.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_STRETCH = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   One-bit two-flop synchroniser with asynchronous active-high clear to 0.
//   Ports:
//     clk  in  1  destination clock
//     clr  in  1  asynchronous active-high clear
//     d    in  1  asynchronous input
//     q    out 1  synchronised output (two clk edges of latency)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq
//   Reset sequencer for the wishbone clock domain. Holds a bank of active-high
//   resets asserted until every lock input has been stable, stretches the
//   reset, then releases the channels one at a time in index order with a
//   fixed gap between releases. Lock loss (before RUN) and software reset
//   requests (in RUN) re-run the whole sequence.
//
//   Parameters:
//     NUM_RST  (1..16) number of reset outputs
//     NUM_LOCK (1..8)  number of lock inputs
//     STRETCH  (>=1)   stable-lock cycles before channel 0 is released
//     GAP      (>=1)   cycles between releases and from last release to ready
//
//   Ports:
//     wb_clk_i    in  1         sole clock
//     async_rst_i in  1         asynchronous active-high reset
//     locked_i    in  NUM_LOCK  lock inputs, asynchronous to wb_clk_i
//     sw_rst_i    in  1         software reset request, only honoured in RUN
//     rst_o       out NUM_RST   active-high resets, channel 0 released first
//     ready_o     out 1         high once every channel is released
//
//   Build option: RST_SEQ_LOCK_LOSS_EN (undefined by default). When defined,
//   lock loss in RUN reasserts the bank; otherwise RUN ignores the locks.
// -----------------------------------------------------------------------------
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_RST  = 4,
    parameter int NUM_LOCK = 2,
    parameter int STRETCH  = 16,
    parameter int GAP      = 8
) (
    input  logic                wb_clk_i,
    input  logic                async_rst_i,
    input  logic [NUM_LOCK-1:0] locked_i,
    input  logic                sw_rst_i,
    output logic [NUM_RST-1:0]  rst_o,
    output logic                ready_o
);

    localparam int CW = $clog2(max_int(STRETCH, GAP) + 1);
    localparam int IW = $clog2(NUM_RST + 1);

    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(GAP - 1);
    localparam logic [IW-1:0] IDX_END      = IW'(NUM_RST);

    // ---------------------------------------------------------------------
    // Lock synchronisers
    // ---------------------------------------------------------------------
    logic [NUM_LOCK-1:0] lock_sync;
    logic                lock_ok;

    for (genvar g = 0; g < NUM_LOCK; g++) begin : g_lock_sync
        sync_2ff u_sync (
            .clk (wb_clk_i),
            .clr (async_rst_i),
            .d   (locked_i[g]),
            .q   (lock_sync[g])
        );
    end

    assign lock_ok = &lock_sync;

    // ---------------------------------------------------------------------
    // Sequencer state
    // ---------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [IW-1:0]       idx_q,   idx_d;
    logic [NUM_RST-1:0]  rst_q,   rst_d;
    logic                ready_q, ready_d;

    always_ff @(posedge wb_clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        ready_d = ready_q;

        case (state_q)
            ST_ASSERT: begin
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                if (lock_ok) begin
                    state_d = ST_STRETCH;
                end
            end

            ST_STRETCH: begin
                if (!lock_ok) begin
                    cnt_d   = '0;
                    state_d = ST_ASSERT;
                end else if (cnt_q == STRETCH_LAST) begin
                    rst_d[0] = 1'b0;
                    idx_d    = IW'(1);
                    cnt_d    = '0;
                    state_d  = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RELEASE: begin
                // Lock loss wins over a release due on the same cycle: the
                // bank is only ever reasserted as a whole.
                if (!lock_ok) begin
                    rst_d   = '1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ASSERT;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q < IDX_END) begin
                        // Decoded clear keeps the index width independent of
                        // the bank width (idx can legally reach NUM_RST).
                        for (int i = 0; i < NUM_RST; i++) begin
                            if (idx_q == IW'(i)) begin
                                rst_d[i] = 1'b0;
                            end
                        end
                        idx_d = idx_q + IW'(1);
                    end else begin
                        ready_d = 1'b1;
                        state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RUN: begin
                if (sw_rst_i) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ASSERT;
                end
`ifdef RST_SEQ_LOCK_LOSS_EN
                else if (!lock_ok) begin
                    rst_d   = '1;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_ASSERT;
                end
`endif
            end

            default: begin
                rst_d   = '1;
                ready_d = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
                state_d = ST_ASSERT;
            end
        endcase
    end

    assign rst_o   = rst_q;
    assign ready_o = ready_q;

endmodule
